// File: rtl/bitty_seq_pkg.sv
// Shared state encoding for the bitty fetch/execute sequencer.
package bitty_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_EXEC   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/bitty_seq_timer.sv
// Clearable up-counter with a terminal-count compare against a fixed value.
module bitty_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/bitty_seq.sv
// Handshake fetch/execute sequencer with halt/single-step and retire counter.
// Optional EXEC watchdog enabled by defining BITTY_SEQ_WDT_EN.
//
// state  | meaning
// IDLE   | waiting for start (or halt_req) after reset
// FETCH  | instruction memory read held for MEM_LAT cycles
// ISSUE  | one-cycle run pulse into the core
// EXEC   | waiting for done from the core
// COMMIT | one-cycle PC advance, retire count update
// HALT   | stopped at an instruction boundary, debug control
module bitty_seq
  import bitty_seq_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int WDT_CYCLES = 64,
  parameter int ICNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   step_req,
  input  logic                   done,
  output logic                   mem_rd,
  output logic                   ir_load,
  output logic                   run,
  output logic                   en_pc,
  output logic                   busy,
  output logic                   halted,
  output logic [SEQ_STATE_W-1:0] state_o,
  output logic [ICNT_W-1:0]      instr_count,
  output logic                   wdt_err
);

  localparam logic [3:0] LAT_TC = 4'(MEM_LAT - 1);

  seq_state_t        state_q, state_d;
  logic              step_q, step_d;
  logic [ICNT_W-1:0] cnt_q, cnt_d;
  logic              lat_tc;

  bitty_seq_timer #(.W(4)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != S_FETCH),
    .inc_i    (state_q == S_FETCH),
    .tc_val_i (LAT_TC),
    .tc_o     (lat_tc)
  );

`ifdef BITTY_SEQ_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_TC = WDT_W'(WDT_CYCLES - 1);

  logic wdt_tc;
  logic wdt_err_q, wdt_err_d;

  bitty_seq_timer #(.W(WDT_W)) u_wdt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != S_EXEC),
    .inc_i    ((state_q == S_EXEC) && !done),
    .tc_val_i (WDT_TC),
    .tc_o     (wdt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdt_err_q <= 1'b0;
    else       wdt_err_q <= wdt_err_d;
  end

  assign wdt_err = wdt_err_q;
`else
  // Watchdog absent; the parameter stays so both builds share one interface.
  assign wdt_err = 1'b0 & (WDT_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
`ifdef BITTY_SEQ_WDT_EN
    wdt_err_d = wdt_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (halt_req)   state_d = S_HALT;
        else if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (lat_tc) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = done ? S_COMMIT : S_EXEC;
      end
      S_EXEC: begin
        if (done) state_d = S_COMMIT;
`ifdef BITTY_SEQ_WDT_EN
        else if (wdt_tc) begin
          state_d   = S_HALT;
          wdt_err_d = 1'b1;
        end
`endif
      end
      S_COMMIT: begin
        cnt_d = cnt_q + 1'b1;
        if (halt_req || step_q) begin
          state_d = S_HALT;
          step_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
`ifdef BITTY_SEQ_WDT_EN
          wdt_err_d = 1'b0;
`endif
        end else if (step_req) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output is a decode of registered state, never of an input.
  assign mem_rd      = (state_q == S_FETCH);
  assign ir_load     = (state_q == S_FETCH) && lat_tc;
  assign run         = (state_q == S_ISSUE);
  assign en_pc       = (state_q == S_COMMIT);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign state_o     = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_bitty_seq.sv
// Scoreboard bench for bitty_seq: instruction-level model, randomized done latency.
module tb_bitty_seq;

  localparam int MEM_LAT    = 3;
  localparam int WDT_CYCLES = 8;
  localparam int ICNT_W     = 4;
  localparam int NEVER      = 255;

  logic              clk, reset, start, halt_req, step_req, done;
  logic              mem_rd, ir_load, run, en_pc, busy, halted, wdt_err;
  logic [2:0]        state_o;
  logic [ICNT_W-1:0] instr_count;

  bitty_seq #(.MEM_LAT(MEM_LAT), .WDT_CYCLES(WDT_CYCLES), .ICNT_W(ICNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .step_req(step_req), .done(done), .mem_rd(mem_rd), .ir_load(ir_load),
    .run(run), .en_pc(en_pc), .busy(busy), .halted(halted),
    .state_o(state_o), .instr_count(instr_count), .wdt_err(wdt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int run_to_pc;
    int gap;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   plan_q[$];
  int   errors = 0;
  int   checks = 0;
  int   model_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One retired instruction: done comes d cycles after run, count advances by one.
  task automatic issue(input int d, input bit chk_gap);
    exp_t e;
    plan_q.push_back(d);
    model_cnt = (model_cnt + 1) % (1 << ICNT_W);
    e.run_to_pc = d + 1;
    e.gap       = chk_gap ? (MEM_LAT + 2 + d) : 0;
    e.cnt       = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_halted(input int max, input string nm);
    int n = 0;
    @(negedge clk);
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(halted), 1);
  endtask

  task automatic wait_run(input int max, input string nm);
    int n = 0;
    while (!run && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(run), 1);
  endtask

  // Core model: answers each run pulse with done after the planned delay.
  initial begin
    int d;
    done = 1'b0;
    forever begin
      @(negedge clk);
      if (run && plan_q.size() > 0) begin
        d = plan_q.pop_front();
        if (d < NEVER) begin
          repeat (d) @(negedge clk);
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
        end
      end
    end
  end

  // Monitor: per-instruction handshake shape checked on each en_pc.
  int cyc = 0, run_cyc = 0, last_pc_cyc = 0;
  int memrd_n = 0, run_n = 0, ir_at = -1;
  bit cnt_pending = 0;
  int cnt_exp = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      memrd_n = 0; run_n = 0; ir_at = -1; cnt_pending = 0;
    end else begin
      if (cnt_pending) begin
        chk("instr_count_after_commit", int'(instr_count), cnt_exp);
        cnt_pending = 0;
      end
      if (halted) begin
        memrd_n = 0; run_n = 0; ir_at = -1;
      end else begin
        if (mem_rd) memrd_n++;
        if (ir_load) ir_at = memrd_n;
        if (run) begin
          run_n++;
          run_cyc = cyc;
        end
        if (en_pc) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_en_pc", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("mem_rd_cycles", memrd_n, MEM_LAT);
            chk("ir_load_on_last_rd", ir_at, MEM_LAT);
            chk("run_pulses", run_n, 1);
            chk("run_to_en_pc", cyc - run_cyc, e.run_to_pc);
            if (e.gap != 0) chk("en_pc_spacing", cyc - last_pc_cyc, e.gap);
            cnt_pending = 1;
            cnt_exp = e.cnt;
          end
          last_pc_cyc = cyc;
          memrd_n = 0; run_n = 0; ir_at = -1;
        end
      end
    end
  end

  initial begin
    int n, t, d, exec_n;
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state_o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_ir_load", int'(ir_load), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_en_pc", int'(en_pc), 0);
    chk("rst_wdt_err", int'(wdt_err), 0);
    chk("rst_count", int'(instr_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // First instruction, halt requested while it executes.
    issue(2, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fetch_busy", int'(busy), 1);
    wait_run(20, "first_run_seen");
    @(negedge clk);
    chk("exec_state", int'(state_o), 3);
    halt_req = 1'b1;
    wait_halted(40, "halt_after_commit");
    halt_req = 1'b0;
    chk("count_after_first", int'(instr_count), model_cnt);

    // Three single steps, each returning to HALT.
    for (int k = 0; k < 3; k++) begin
      issue($urandom_range(0, 4), 0);
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      wait_halted(40, "step_rehalt");
      chk("step_count", int'(instr_count), model_cnt);
    end
    chk("step_queue_drained", exp_q.size(), 0);

    // Spurious done while halted.
    done = 1'b1;
    repeat (2) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk("halt_spurious_state", int'(state_o), 5);
    chk("halt_spurious_count", int'(instr_count), model_cnt);

    // start with halt_req held: one instruction then halt again.
    issue($urandom_range(0, 3), 0);
    halt_req = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halted(40, "start_halt_rehalt");
    halt_req = 1'b0;
    chk("start_halt_count", int'(instr_count), model_cnt);

    // Free run of 17: ten zero-wait, then random waits; the count wraps.
    for (int i = 0; i < 17; i++) issue((i < 10) ? 0 : $urandom_range(0, 3), i > 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; t = 0;
    while (n < 16 && t < 1000) begin
      @(negedge clk);
      t++;
      if (en_pc) n++;
    end
    chk("freerun_commits_seen", n, 16);
    @(negedge clk);
    halt_req = 1'b1;
    wait_halted(40, "freerun_halt");
    halt_req = 1'b0;
    chk("freerun_count_wrap", int'(instr_count), model_cnt);
    chk("freerun_queue_drained", exp_q.size(), 0);

`ifdef BITTY_SEQ_WDT_EN
    // Watchdog: done withheld, expiry halts without committing.
    plan_q.push_back(NEVER);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exec_n = 0; t = 0;
    while (!halted && t < 200) begin
      if (state_o == 3'd3) exec_n++;
      @(negedge clk);
      t++;
    end
    chk("wdt_halted", int'(halted), 1);
    chk("wdt_exec_cycles", exec_n, WDT_CYCLES);
    chk("wdt_err_set", int'(wdt_err), 1);
    chk("wdt_count_kept", int'(instr_count), model_cnt);
    issue(1, 0);
    halt_req = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wdt_err_cleared", int'(wdt_err), 0);
    chk("wdt_restart_fetch", int'(state_o), 1);
    wait_halted(40, "wdt_restart_rehalt");
    halt_req = 1'b0;
    chk("wdt_restart_count", int'(instr_count), model_cnt);
`else
    d = 0;
    exec_n = 0;
    chk("wdt_err_tied_low", int'(wdt_err) + d + exec_n, 0);
`endif

    // Asynchronous reset in the middle of EXEC.
    plan_q.push_back(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_run(20, "rst_test_run_seen");
    repeat (2) @(negedge clk);
    chk("pre_reset_exec", int'(state_o), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_run", int'(run), 0);
    chk("async_rst_en_pc", int'(en_pc), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_count", int'(instr_count), 0);
    model_cnt = 0;
    exp_q.delete();
    plan_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Spurious done in IDLE.
    done = 1'b1;
    repeat (2) @(negedge clk);
    done = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_spurious_state", int'(state_o), 0);
    chk("idle_spurious_count", int'(instr_count), 0);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitty_seq.md
Name: bitty_seq

Overview:
- Fetch/execute sequencer for the bitty core.
- Replaces the free-running 4-state run counter with a handshake-driven controller. It:
  - holds the instruction memory read for a fixed latency;
  - latches the instruction and pulses run into the core;
  - waits for done, then enables the PC for exactly one cycle.
- Adds halt/single-step control and a retired-instruction counter for debug through the top-level ui_in/uo_out pins.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_rd assertion to valid instruction; legal range 1..15.
- WDT_CYCLES, 64, maximum EXEC cycles allowed before done (used only with the watchdog feature).
- ICNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; leaves IDLE, or resumes free-running from HALT.
- halt_req  in  1  level; halts at the next instruction boundary.
- step_req  in  1  pulse; in HALT, executes exactly one instruction.
- done  in  1  core completion pulse.
- mem_rd  out  1  instruction memory read strobe.
- ir_load  out  1  instruction register capture enable.
- run  out  1  one-cycle start pulse to the core.
- en_pc  out  1  one-cycle PC advance enable.
- busy  out  1  high when the state is not IDLE and not HALT.
- halted  out  1  high in HALT.
- state_o  out  3  current state encoding.
- instr_count  out  ICNT_W  retired-instruction count.
- wdt_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All 1-bit outputs are 0; instr_count is 0; latency counter, watchdog counter and step flag are 0.
- States and encodings: IDLE=0, FETCH=1, ISSUE=2, EXEC=3, COMMIT=4, HALT=5. Codes 6 and 7 go to IDLE on the next clock.
- All outputs are registered or decoded purely from state; no input-to-output combinational path.
- IDLE:
  - halt_req=1 -> HALT (this has priority over start).
  - start=1 -> FETCH.
- FETCH:
  - mem_rd=1 for MEM_LAT consecutive cycles.
  - The latency counter is loaded with 0 on entry.
  - On the last cycle (count == MEM_LAT-1), ir_load=1 and the next state is ISSUE.
- ISSUE:
  - run=1 for exactly this cycle.
  - done=1 in this cycle -> COMMIT directly (zero-wait instructions); otherwise -> EXEC.
- EXEC: stays until done=1, then -> COMMIT. No run re-assertion.
- COMMIT:
  - en_pc=1 for exactly one cycle; instr_count increments and wraps from 2^ICNT_W-1 to 0.
  - Next state is HALT if halt_req=1 or the step flag is set; in that case the step flag clears. Otherwise -> FETCH.
- HALT:
  - halted=1.
  - start=1 -> FETCH with the step flag cleared (free-run).
  - Otherwise step_req=1 -> FETCH with the step flag set.
  - start and step_req in the same cycle: start wins.
  - halt_req held high together with start re-halts after one instruction.
- done outside ISSUE/EXEC is ignored; it produces no en_pc and no count change.
- halt_req is never acted on mid-instruction; the current instruction always commits.
- Latency, from the FETCH entry edge with MEM_LAT=1 and done in the ISSUE cycle: run is asserted at cycle 2 and en_pc at cycle 3; 3 cycles per instruction minimum.

Optional Feature:
- Macro BITTY_SEQ_WDT_EN.
- Defined:
  - The watchdog counter clears on EXEC entry and counts each EXEC cycle without done.
  - When it reaches WDT_CYCLES-1 with done=0, wdt_err is set and the next state is HALT, skipping COMMIT: no en_pc and no count change.
  - If done and expiry occur in the same cycle, done wins.
  - wdt_err is sticky; it is cleared only by reset or by start in HALT.
- Not defined: EXEC waits indefinitely; wdt_err is tied to 0; no watchdog counter is synthesised.

Decomposition:
- Package bitty_seq_pkg holds:
  - the enum seq_state_t (3-bit, encodings as above);
  - the localparam SEQ_STATE_W=3.
- One natural sub-module: bitty_seq_timer, a loadable up-counter with a terminal-count compare. It is instantiated once for the FETCH latency and once for the watchdog, the latter under the macro.

Test Plan:
- Reset mid-EXEC: assert reset asynchronously -> state_o=0 and run/en_pc/busy=0 in the same cycle; instr_count=0.
- MEM_LAT=3, start=1, done returned 2 cycles after run -> mem_rd high for 3 cycles, ir_load on the 3rd; run one pulse; en_pc one pulse; instr_count=1.
- Free-run, done in the ISSUE cycle, 10 instructions -> en_pc every 3rd cycle (MEM_LAT=1); instr_count=10.
- halt_req raised during EXEC -> the instruction still commits (en_pc=1), then halted=1; three step_req pulses -> exactly 3 en_pc pulses and a return to HALT each time.
- Spurious done in IDLE and in HALT -> no en_pc, instr_count unchanged. ICNT_W=4 with 17 instructions -> instr_count=1 (wrap).
- With BITTY_SEQ_WDT_EN and WDT_CYCLES=8, done withheld -> wdt_err=1 and HALT after 8 EXEC cycles with no en_pc; then start -> wdt_err=0 and FETCH.
